// File: rtl/pic_pkg.sv
// pic_pkg -- shared definitions for the interrupt-acknowledge sequencer.
// Contents:
//   IR_LEVELS, LEVEL_W, VEC_BASE_W : widths of the IR level and vector fields
//   SPURIOUS_LEVEL                 : level reported when a request vanishes at acknowledge
//   seq_state_e                    : acknowledge sequencer state enumeration
//   level_onehot()                 : IR level to one-hot ISR pulse vector
package pic_pkg;

    localparam int IR_LEVELS  = 8;
    localparam int LEVEL_W    = 3;
    localparam int VEC_BASE_W = 5;

    localparam logic [LEVEL_W-1:0] SPURIOUS_LEVEL = 3'd7;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        INT_ASSERT = 3'd1,
        ACK1       = 3'd2,
        GAP        = 3'd3,
        ACK2       = 3'd4,
        DONE       = 3'd5
    } seq_state_e;

    function automatic logic [IR_LEVELS-1:0] level_onehot(input logic [LEVEL_W-1:0] lvl);
        logic [IR_LEVELS-1:0] v;
        v      = '0;
        v[lvl] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/inta_sync.sv
// inta_sync -- synchronizer and edge detector for the CPU acknowledge strobe.
// Ports:
//   CLK    in  system clock, rising edge
//   RST_N  in  asynchronous active-low reset; all flops reset to 1 (INTA inactive)
//   INTA_N in  asynchronous active-low acknowledge from the CPU
//   FALL   out one-cycle pulse: synchronized INTA_N went 1 -> 0 (acknowledge start)
//   RISE   out one-cycle pulse: synchronized INTA_N went 0 -> 1 (acknowledge end)
module inta_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic CLK,
    input  logic RST_N,
    input  logic INTA_N,
    output logic FALL,
    output logic RISE
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;
    logic                   synced;

    assign synced = sync_q[SYNC_STAGES-1];

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            sync_q <= '1;
            prev_q <= 1'b1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], INTA_N};
            prev_q <= synced;
        end
    end

    // Edges come from two registered samples of the synchronized level, so each
    // is a clean single-cycle pulse; a glitch that misses every clock edge never
    // enters the chain and produces nothing.
    assign FALL = prev_q & ~synced;
    assign RISE = ~prev_q & synced;

endmodule

// File: rtl/inta_sequencer.sv
// inta_sequencer -- drives INT to the CPU and runs the two-pulse INTA
// acknowledge cycle of an 8259-style interrupt controller.
// Ports:
//   CLK, RST_N   clock (rising edge) and asynchronous active-low reset
//   REQ_VALID    resolver has an unmasked pending request
//   REQ_LEVEL    winning IR level 0..7
//   ICW2_BASE    vector bits T7..T3, sampled when the second INTA starts
//   AEOI         automatic end-of-interrupt enable, sampled in DONE
//   INTA_N       asynchronous active-low CPU acknowledge
//   INT          interrupt request to the CPU
//   DATA_OUT     vector byte {ICW2_BASE, level}
//   DATA_OE      bus drive enable, high only during the second INTA pulse
//   ISR_SET      one-hot single-cycle pulse at the first acknowledge
//   ISR_CLR      one-hot single-cycle pulse after DONE when AEOI is set
//   BUSY         high in every state except IDLE
module inta_sequencer
    import pic_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic                  REQ_VALID,
    input  logic [LEVEL_W-1:0]    REQ_LEVEL,
    input  logic [VEC_BASE_W-1:0] ICW2_BASE,
    input  logic                  AEOI,
    input  logic                  INTA_N,
    output logic                  INT,
    output logic [7:0]            DATA_OUT,
    output logic                  DATA_OE,
    output logic [IR_LEVELS-1:0]  ISR_SET,
    output logic [IR_LEVELS-1:0]  ISR_CLR,
    output logic                  BUSY
);

    logic inta_fall;
    logic inta_rise;

    inta_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_inta_sync (
        .CLK    (CLK),
        .RST_N  (RST_N),
        .INTA_N (INTA_N),
        .FALL   (inta_fall),
        .RISE   (inta_rise)
    );

    seq_state_e           state_q;
    logic                 int_q;
    logic                 data_oe_q;
    logic [7:0]           data_out_q;
    logic [IR_LEVELS-1:0] isr_set_q;
    logic [IR_LEVELS-1:0] isr_clr_q;
    logic [LEVEL_W-1:0]   level_q;
    logic                 spurious_q;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q    <= IDLE;
            int_q      <= 1'b0;
            data_oe_q  <= 1'b0;
            data_out_q <= '0;
            isr_set_q  <= '0;
            isr_clr_q  <= '0;
            level_q    <= '0;
            spurious_q <= 1'b0;
        end else begin
            // ISR pulses are single-cycle: cleared unless re-armed below.
            isr_set_q <= '0;
            isr_clr_q <= '0;

            case (state_q)
                IDLE: begin
                    // Acknowledge edges with no INT outstanding are ignored here.
                    if (REQ_VALID) begin
                        state_q <= INT_ASSERT;
                        int_q   <= 1'b1;
                        level_q <= REQ_LEVEL;
                    end
                end

                INT_ASSERT: begin
                    if (inta_fall) begin
                        int_q   <= 1'b0;
                        state_q <= ACK1;
                        if (REQ_VALID) begin
                            level_q    <= REQ_LEVEL;
                            spurious_q <= 1'b0;
                            isr_set_q  <= level_onehot(REQ_LEVEL);
                        end else begin
                            // Request withdrawn exactly at acknowledge: the CPU
                            // still expects a vector, so hand it the IR7 vector
                            // without touching the ISR.
                            level_q    <= SPURIOUS_LEVEL;
                            spurious_q <= 1'b1;
                        end
                    end else if (!REQ_VALID) begin
                        int_q   <= 1'b0;
                        state_q <= IDLE;
                    end else begin
                        // Keep following the resolver so a higher-priority
                        // request can preempt before the CPU acknowledges.
                        level_q <= REQ_LEVEL;
                    end
                end

                ACK1: begin
                    // First INTA pulse leaves the bus floating.
                    if (inta_rise) begin
                        state_q <= GAP;
                    end
                end

                GAP: begin
                    if (inta_fall) begin
                        state_q    <= ACK2;
                        data_oe_q  <= 1'b1;
                        data_out_q <= {ICW2_BASE, level_q};
                    end
                end

                ACK2: begin
                    if (inta_rise) begin
                        state_q    <= DONE;
                        data_oe_q  <= 1'b0;
                        data_out_q <= '0;
                    end
                end

                DONE: begin
                    state_q <= IDLE;
                    if (AEOI && !spurious_q) begin
                        isr_clr_q <= level_onehot(level_q);
                    end
                end

                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign INT      = int_q;
    assign DATA_OE  = data_oe_q;
    assign DATA_OUT = data_out_q;
    assign ISR_SET  = isr_set_q;
    assign ISR_CLR  = isr_clr_q;
    assign BUSY     = (state_q != IDLE);

endmodule
